// File: rtl/ext_bus_bridge_pkg.sv
// Purpose: shared types and helpers for the CPU-to-external-bus bridge.
// Latency: none (types, constants and pure functions only).
// Backpressure: n/a.
package ext_bus_bridge_pkg;

    // Transaction sequencer states, in bus-phase order.
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        A_HI  = 3'd1,
        A_MID = 3'd2,
        A_LO  = 3'd3,
        DATA  = 3'd4,
        DONE  = 3'd5,
        TURN  = 3'd6
    } state_e;

    // Width of the per-byte wait-state counter (WAIT is 0..15).
    localparam int WAIT_W = 4;

    // Byte lanes carried by a CPU word of width rv.
    function automatic int nb_of(input int rv);
        return rv / 8;
    endfunction

    // Address bits below the word address (log2 of the lane count).
    function automatic int lsb_of(input int rv);
        return (rv == 32) ? 2 : 1;
    endfunction

    // Pick byte idx of a zero-extended 24-bit byte address.
    function automatic logic [7:0] addr_byte(input logic [23:0] a, input logic [1:0] idx);
        return a[{idx, 3'b000} +: 8];
    endfunction

endpackage

// File: rtl/ext_bus_waitctr.sv
// Purpose: per-byte wait-state down-counter qualified by external ready.
// Latency: byte_last is combinational from the counter and ext_rdy.
// Backpressure: ext_rdy=0 holds byte_last low indefinitely once the count expires.
module ext_bus_waitctr
    import ext_bus_bridge_pkg::*;
#(
    parameter int WAIT = 0
) (
    input  logic clk,
    input  logic reset,
    input  logic ena,
    input  logic active,
    input  logic ext_rdy,
    output logic byte_last
);

    logic [WAIT_W-1:0] cnt_q;
    logic [WAIT_W-1:0] cnt_d;

    // Reload outside DATA and after each finished byte, otherwise count down to zero.
    always_comb begin
        byte_last = active && (cnt_q == '0) && ext_rdy;
        cnt_d     = cnt_q;
        if (!active || byte_last) begin
            cnt_d = WAIT_W'(WAIT);
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    // Counter register; ena=0 freezes it along with the rest of the bridge.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= WAIT_W'(WAIT);
        end else if (ena) begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/ext_bus_bridge.sv
// Purpose: sequences a byte-masked CPU read/write onto an 8-bit muxed address/data bus.
// Latency: miss = 3 address cycles + (1+WAIT) per set lane + done; cache hit skips A_HI/A_MID.
// Backpressure: ext_rdy=0 stretches the current data byte; ena=0 freezes all state.
module ext_bus_bridge
    import ext_bus_bridge_pkg::*;
#(
    parameter int RV         = 16,
    parameter int PA         = 22,
    parameter int WAIT       = 0,
    parameter int ADDR_CACHE = 1,
    localparam int NB        = nb_of(RV),
    localparam int LSB       = lsb_of(RV),
    localparam int BSW       = LSB,
    localparam int AW        = PA - LSB,
    localparam int CW        = PA - 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          ena,
    input  logic [AW-1:0] addrp,
    input  logic [NB-1:0] rreq,
    input  logic [NB-1:0] wmask,
    input  logic [RV-1:0] wdata,
    output logic [RV-1:0] rdata,
    output logic          rdone,
    output logic          wdone,
    output logic [7:0]    bus_out,
    input  logic [7:0]    bus_in,
    output logic          latch_hi,
    output logic          latch_lo,
    output logic          wr,
    output logic [BSW-1:0] bsel,
    input  logic          ext_rdy
);

    state_e         state_q, state_d;
    logic           is_wr_q, is_wr_d;
    logic [NB-1:0]  rem_q, rem_d;
    logic [AW-1:0]  addr_q, addr_d;
    logic [RV-1:0]  wdata_q, wdata_d;
    logic [CW-1:0]  cache_q, cache_d;
    logic           cache_vld_q, cache_vld_d;

    logic [7:0]     bus_out_q, bus_out_d;
    logic           latch_hi_q, latch_hi_d;
    logic           latch_lo_q, latch_lo_d;
    logic           wr_q, wr_d;
    logic [BSW-1:0] bsel_q, bsel_d;
    logic           rdone_q, rdone_d;
    logic           wdone_q, wdone_d;
    logic [RV-1:0]  rdata_q, rdata_d;

    logic           byte_last;
    logic           cache_hit;
    logic [BSW-1:0] lane_nxt;
    logic [23:0]    a24;

    assign cache_hit = (ADDR_CACHE != 0) && cache_vld_q && (addrp[AW-1 -: CW] == cache_q);

    ext_bus_waitctr #(.WAIT(WAIT)) u_waitctr (
        .clk       (clk),
        .reset     (reset),
        .ena       (ena),
        .active    (state_q == DATA),
        .ext_rdy   (ext_rdy),
        .byte_last (byte_last)
    );

    // Next state, transaction capture, lane retirement and read-data capture.
    always_comb begin
        state_d     = state_q;
        is_wr_d     = is_wr_q;
        rem_d       = rem_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        cache_d     = cache_q;
        cache_vld_d = cache_vld_q;
        rdata_d     = rdata_q;
        case (state_q)
            IDLE: begin
                if (|wmask) begin
                    is_wr_d = 1'b1;
                    rem_d   = wmask;
                end else if (|rreq) begin
                    is_wr_d = 1'b0;
                    rem_d   = rreq;
                end
                if ((|wmask) || (|rreq)) begin
                    addr_d  = addrp;
                    wdata_d = wdata;
                    state_d = cache_hit ? A_LO : A_HI;
                end
            end
            A_HI: state_d = A_MID;
            A_MID: begin
                cache_d     = addr_q[AW-1 -: CW];
                cache_vld_d = 1'b1;
                state_d     = A_LO;
            end
            A_LO: state_d = DATA;
            DATA: begin
                if (byte_last) begin
                    if (!is_wr_q) begin
                        rdata_d[{bsel_q, 3'b000} +: 8] = bus_in;
                    end
                    rem_d[bsel_q] = 1'b0;
                    if (rem_d == '0) begin
                        state_d = DONE;
                    end
                end
            end
            DONE:    state_d = TURN;
            TURN:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Lowest still-pending lane: the lane driven in the next DATA cycle.
    always_comb begin
        lane_nxt = '0;
        for (int i = NB - 1; i >= 0; i--) begin
            if (rem_d[i]) begin
                lane_nxt = BSW'(i);
            end
        end
    end

    // Output values for the state being entered, so pins change with the state register.
    always_comb begin
        a24        = 24'({addr_d, {LSB{1'b0}}});
        bus_out_d  = bus_out_q;
        latch_hi_d = 1'b0;
        latch_lo_d = 1'b0;
        wr_d       = 1'b0;
        bsel_d     = bsel_q;
        rdone_d    = 1'b0;
        wdone_d    = 1'b0;
        case (state_d)
            A_HI: begin
                bus_out_d  = addr_byte(a24, 2'd2);
                latch_hi_d = 1'b1;
            end
            A_MID: begin
                bus_out_d  = addr_byte(a24, 2'd1);
                latch_hi_d = 1'b1;
                latch_lo_d = 1'b1;
            end
            A_LO: begin
                bus_out_d  = addr_byte(a24, 2'd0);
                latch_lo_d = 1'b1;
            end
            DATA: begin
                bsel_d = lane_nxt;
                if (is_wr_d) begin
                    bus_out_d = wdata_d[{lane_nxt, 3'b000} +: 8];
                    wr_d      = 1'b1;
                end
            end
            DONE: begin
                rdone_d = !is_wr_d;
                wdone_d = is_wr_d;
            end
            default: ;
        endcase
    end

    // State and output registers; reset beats ena, ena=0 holds everything.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            is_wr_q     <= 1'b0;
            rem_q       <= '0;
            addr_q      <= '0;
            wdata_q     <= '0;
            cache_q     <= '0;
            cache_vld_q <= 1'b0;
            bus_out_q   <= '0;
            latch_hi_q  <= 1'b0;
            latch_lo_q  <= 1'b0;
            wr_q        <= 1'b0;
            bsel_q      <= '0;
            rdone_q     <= 1'b0;
            wdone_q     <= 1'b0;
            rdata_q     <= '0;
        end else if (ena) begin
            state_q     <= state_d;
            is_wr_q     <= is_wr_d;
            rem_q       <= rem_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            cache_q     <= cache_d;
            cache_vld_q <= cache_vld_d;
            bus_out_q   <= bus_out_d;
            latch_hi_q  <= latch_hi_d;
            latch_lo_q  <= latch_lo_d;
            wr_q        <= wr_d;
            bsel_q      <= bsel_d;
            rdone_q     <= rdone_d;
            wdone_q     <= wdone_d;
            rdata_q     <= rdata_d;
        end
    end

    assign bus_out  = bus_out_q;
    assign latch_hi = latch_hi_q;
    assign latch_lo = latch_lo_q;
    assign wr       = wr_q;
    assign bsel     = bsel_q;
    assign rdone    = rdone_q;
    assign wdone    = wdone_q;
    assign rdata    = rdata_q;

endmodule

// File: tb/tb_ext_bus_bridge.sv
// Purpose: directed self-checking bench for ext_bus_bridge (RV=16/WAIT=0 and RV=32/WAIT=2).
// Latency: per-cycle vector table for the 16-bit instance, hand sequences for the rest.
// Backpressure: exercises ext_rdy stretch and ena freeze.
module tb_ext_bus_bridge;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    // 16-bit instance signals
    logic        ena16, rdone16, wdone16, latch_hi16, latch_lo16, wr16, bsel16, ext_rdy16;
    logic [20:0] addrp16;
    logic [1:0]  rreq16, wmask16;
    logic [15:0] wdata16, rdata16;
    logic [7:0]  bus_out16, bus_in16;

    // 32-bit instance signals
    logic        ena32, rdone32, wdone32, latch_hi32, latch_lo32, wr32, ext_rdy32;
    logic [19:0] addrp32;
    logic [3:0]  rreq32, wmask32;
    logic [31:0] wdata32, rdata32;
    logic [7:0]  bus_out32, bus_in32;
    logic [1:0]  bsel32;

    ext_bus_bridge #(.RV(16), .PA(22), .WAIT(0), .ADDR_CACHE(1)) u16 (
        .clk(clk), .reset(reset), .ena(ena16), .addrp(addrp16), .rreq(rreq16),
        .wmask(wmask16), .wdata(wdata16), .rdata(rdata16), .rdone(rdone16),
        .wdone(wdone16), .bus_out(bus_out16), .bus_in(bus_in16), .latch_hi(latch_hi16),
        .latch_lo(latch_lo16), .wr(wr16), .bsel(bsel16), .ext_rdy(ext_rdy16)
    );

    ext_bus_bridge #(.RV(32), .PA(22), .WAIT(2), .ADDR_CACHE(1)) u32 (
        .clk(clk), .reset(reset), .ena(ena32), .addrp(addrp32), .rreq(rreq32),
        .wmask(wmask32), .wdata(wdata32), .rdata(rdata32), .rdone(rdone32),
        .wdone(wdone32), .bus_out(bus_out32), .bus_in(bus_in32), .latch_hi(latch_hi32),
        .latch_lo(latch_lo32), .wr(wr32), .bsel(bsel32), .ext_rdy(ext_rdy32)
    );

    typedef struct packed {
        logic [7:0]  bus;
        logic        lh;
        logic        ll;
        logic        wr;
        logic        bs;
        logic        rd;
        logic        wd;
        logic [15:0] rdata;
    } out16_t;

    typedef struct {
        logic        ena;
        logic [1:0]  wm;
        logic [1:0]  rr;
        logic [20:0] addr;
        logic [15:0] wdat;
        logic [7:0]  bi;
        out16_t      exp;
    } vec_t;

    vec_t   vecs[$];
    out16_t o16;
    assign o16 = {bus_out16, latch_hi16, latch_lo16, wr16, bsel16, rdone16, wdone16, rdata16};

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic add(input logic en, input logic [1:0] wm, input logic [1:0] rr,
                       input logic [20:0] a, input logic [15:0] wd, input logic [7:0] bi,
                       input logic [7:0] bus, input logic lh, input logic ll, input logic w,
                       input logic bs, input logic rd, input logic wdn, input logic [15:0] rdat);
        vec_t v;
        v.ena = en; v.wm = wm; v.rr = rr; v.addr = a; v.wdat = wd; v.bi = bi;
        v.exp = {bus, lh, ll, w, bs, rd, wdn, rdat};
        vecs.push_back(v);
    endtask

    // One read on the 32-bit instance, measuring cycles spent on each lane.
    task automatic u32_read(input string name, input logic [3:0] rr, input bit stretch,
                            input logic [31:0] exp_rdata, input int l0, input int l1,
                            input int l2, input int l3);
        int cnt[4];
        bit seen_lo, got_done;
        cnt = '{0, 0, 0, 0};
        seen_lo = 0; got_done = 0;
        rreq32 = rr; addrp32 = 20'h12345; ext_rdy32 = 1'b1;
        bus_in32 = stretch ? 8'hA1 : 8'h11;
        for (int c = 0; c < 80 && !got_done; c++) begin
            @(posedge clk); #1;
            if (rdone32) begin
                got_done = 1;
                rreq32 = '0;
            end else if (latch_lo32 || latch_hi32) begin
                seen_lo = 1;
            end else if (seen_lo) begin
                cnt[bsel32]++;
            end
            ext_rdy32 = 1'b1;
            if (stretch && seen_lo && !got_done && bsel32 == 2'd1 && cnt[1] >= 3 && cnt[1] <= 5)
                ext_rdy32 = 1'b0;
            if (stretch) bus_in32 = (bsel32 == 2'd1) ? 8'hA1 : 8'hB3;
        end
        check({name, "_done"}, 64'(got_done), 64'd1);
        check({name, "_lane0"}, 64'(cnt[0]), 64'(l0));
        check({name, "_lane1"}, 64'(cnt[1]), 64'(l1));
        check({name, "_lane2"}, 64'(cnt[2]), 64'(l2));
        check({name, "_lane3"}, 64'(cnt[3]), 64'(l3));
        check({name, "_rdata"}, 64'(rdata32), 64'(exp_rdata));
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial begin
        bit seen, bad, got;
        logic [7:0] wbyte;

        reset = 1'b1;
        ena16 = 1'b1; rreq16 = '0; wmask16 = '0; addrp16 = '0; wdata16 = '0;
        bus_in16 = '0; ext_rdy16 = 1'b1;
        ena32 = 1'b1; rreq32 = '0; wmask32 = '0; addrp32 = '0; wdata32 = '0;
        bus_in32 = '0; ext_rdy32 = 1'b1;

        // Vector table: inputs sampled at an edge, outputs expected just after it.
        // write 0xBEEF to byte address 0x2468A (cache miss)
        add(1, 2'b11, 2'b00, 21'h12345, 16'hBEEF, 8'h00, 8'h02, 1, 0, 0, 0, 0, 0, 16'h0000);
        add(1, 2'b11, 2'b00, 21'h12345, 16'hBEEF, 8'h00, 8'h46, 1, 1, 0, 0, 0, 0, 16'h0000);
        add(1, 2'b11, 2'b00, 21'h12345, 16'hBEEF, 8'h00, 8'h8A, 0, 1, 0, 0, 0, 0, 16'h0000);
        add(1, 2'b11, 2'b00, 21'h12345, 16'hBEEF, 8'h00, 8'hEF, 0, 0, 1, 0, 0, 0, 16'h0000);
        add(1, 2'b11, 2'b00, 21'h12345, 16'hBEEF, 8'h00, 8'hBE, 0, 0, 1, 1, 0, 0, 16'h0000);
        add(1, 2'b11, 2'b00, 21'h12345, 16'hBEEF, 8'h00, 8'hBE, 0, 0, 0, 1, 0, 1, 16'h0000);
        add(1, 2'b00, 2'b00, 21'h12345, 16'hBEEF, 8'h00, 8'hBE, 0, 0, 0, 1, 0, 0, 16'h0000);
        add(1, 2'b00, 2'b00, 21'h12345, 16'hBEEF, 8'h00, 8'hBE, 0, 0, 0, 1, 0, 0, 16'h0000);
        // read lane 0 at 0x246A0 (cache hit), bus_in 0x33
        add(1, 2'b00, 2'b01, 21'h12350, 16'h0000, 8'h33, 8'hA0, 0, 1, 0, 1, 0, 0, 16'h0000);
        add(1, 2'b00, 2'b01, 21'h12350, 16'h0000, 8'h33, 8'hA0, 0, 0, 0, 0, 0, 0, 16'h0000);
        add(1, 2'b00, 2'b01, 21'h12350, 16'h0000, 8'h33, 8'hA0, 0, 0, 0, 0, 1, 0, 16'h0033);
        add(1, 2'b00, 2'b00, 21'h12350, 16'h0000, 8'h33, 8'hA0, 0, 0, 0, 0, 0, 0, 16'h0033);
        add(1, 2'b00, 2'b00, 21'h12350, 16'h0000, 8'h33, 8'hA0, 0, 0, 0, 0, 0, 0, 16'h0033);
        // read lane 1 only, bus_in 0x5A; lane 0 must keep 0x33
        add(1, 2'b00, 2'b10, 21'h12350, 16'h0000, 8'h5A, 8'hA0, 0, 1, 0, 0, 0, 0, 16'h0033);
        add(1, 2'b00, 2'b10, 21'h12350, 16'h0000, 8'h5A, 8'hA0, 0, 0, 0, 1, 0, 0, 16'h0033);
        add(1, 2'b00, 2'b10, 21'h12350, 16'h0000, 8'h5A, 8'hA0, 0, 0, 0, 1, 1, 0, 16'h5A33);
        add(1, 2'b00, 2'b00, 21'h12350, 16'h0000, 8'h5A, 8'hA0, 0, 0, 0, 1, 0, 0, 16'h5A33);
        add(1, 2'b00, 2'b00, 21'h12350, 16'h0000, 8'h5A, 8'hA0, 0, 0, 0, 1, 0, 0, 16'h5A33);
        // write lane 0 with a full read request alongside: write wins, no read
        add(1, 2'b01, 2'b11, 21'h12351, 16'h1177, 8'h5A, 8'hA2, 0, 1, 0, 1, 0, 0, 16'h5A33);
        add(1, 2'b01, 2'b11, 21'h12351, 16'h1177, 8'h5A, 8'h77, 0, 0, 1, 0, 0, 0, 16'h5A33);
        add(1, 2'b01, 2'b11, 21'h12351, 16'h1177, 8'h5A, 8'h77, 0, 0, 0, 0, 0, 1, 16'h5A33);
        add(1, 2'b00, 2'b00, 21'h12351, 16'h1177, 8'h5A, 8'h77, 0, 0, 0, 0, 0, 0, 16'h5A33);
        add(1, 2'b00, 2'b00, 21'h12351, 16'h1177, 8'h5A, 8'h77, 0, 0, 0, 0, 0, 0, 16'h5A33);
        // write lane 1 to 0x1579A (miss), ena low for 4 cycles in A_MID
        add(1, 2'b10, 2'b00, 21'h0ABCD, 16'h4400, 8'h00, 8'h01, 1, 0, 0, 0, 0, 0, 16'h5A33);
        add(1, 2'b10, 2'b00, 21'h0ABCD, 16'h4400, 8'h00, 8'h57, 1, 1, 0, 0, 0, 0, 16'h5A33);
        for (int k = 0; k < 4; k++)
            add(0, 2'b10, 2'b00, 21'h0ABCD, 16'h4400, 8'h00, 8'h57, 1, 1, 0, 0, 0, 0, 16'h5A33);
        add(1, 2'b10, 2'b00, 21'h0ABCD, 16'h4400, 8'h00, 8'h9A, 0, 1, 0, 0, 0, 0, 16'h5A33);
        add(1, 2'b10, 2'b00, 21'h0ABCD, 16'h4400, 8'h00, 8'h44, 0, 0, 1, 1, 0, 0, 16'h5A33);
        add(1, 2'b10, 2'b00, 21'h0ABCD, 16'h4400, 8'h00, 8'h44, 0, 0, 0, 1, 0, 1, 16'h5A33);
        add(1, 2'b00, 2'b00, 21'h0ABCD, 16'h4400, 8'h00, 8'h44, 0, 0, 0, 1, 0, 0, 16'h5A33);
        add(1, 2'b00, 2'b00, 21'h0ABCD, 16'h4400, 8'h00, 8'h44, 0, 0, 0, 1, 0, 0, 16'h5A33);

        repeat (2) @(posedge clk);
        #1;
        check("reset16", 64'(o16), 64'd0);
        check("reset32", 64'({bus_out32, latch_hi32, latch_lo32, wr32, bsel32, rdone32, wdone32, rdata32}), 64'd0);
        reset = 1'b0;

        foreach (vecs[i]) begin
            ena16 = vecs[i].ena; wmask16 = vecs[i].wm; rreq16 = vecs[i].rr;
            addrp16 = vecs[i].addr; wdata16 = vecs[i].wdat; bus_in16 = vecs[i].bi;
            @(posedge clk); #1;
            check($sformatf("row%0d", i), 64'(o16), 64'(vecs[i].exp));
        end

        // RV=32, WAIT=2: plain lanes 0/2, then lanes 1/3 with lane 1 stretched by ext_rdy
        u32_read("rd32_0101", 4'b0101, 0, 32'h0011_0011, 3, 0, 3, 0);
        u32_read("rd32_1010", 4'b1010, 1, 32'hB311_A111, 0, 6, 0, 3);

        // Reset while parked in DATA (ext_rdy low), then the same address must miss
        wmask16 = 2'b01; addrp16 = 21'h12345; wdata16 = 16'h00C3; ext_rdy16 = 1'b0;
        seen = 0;
        for (int c = 0; c < 10 && !seen; c++) begin
            @(posedge clk); #1;
            if (wr16) seen = 1;
        end
        check("reach_data", 64'(seen), 64'd1);
        reset = 1'b1;
        @(posedge clk); #1;
        check("reset_mid_data", 64'(o16), 64'd0);
        reset = 1'b0; wmask16 = '0; ext_rdy16 = 1'b1;
        bad = 0;
        repeat (4) begin
            @(posedge clk); #1;
            if (rdone16 || wdone16 || latch_hi16 || latch_lo16 || wr16) bad = 1;
        end
        check("quiet_after_reset", 64'(bad), 64'd0);
        wmask16 = 2'b01;
        @(posedge clk); #1;
        check("refetch_a_hi", 64'({latch_hi16, latch_lo16, bus_out16}), 64'({2'b10, 8'h02}));
        @(posedge clk); #1;
        check("refetch_a_mid", 64'({latch_hi16, latch_lo16, bus_out16}), 64'({2'b11, 8'h46}));
        got = 0; wbyte = '0;
        for (int c = 0; c < 10 && !got; c++) begin
            @(posedge clk); #1;
            if (wr16) wbyte = bus_out16;
            if (wdone16) got = 1;
        end
        wmask16 = '0;
        check("refetch_wdone", 64'(got), 64'd1);
        check("refetch_wbyte", 64'(wbyte), 64'h00C3);
        repeat (2) @(posedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
